if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Instruction-fetch stage of the five-stage RV64 core. It owns the fetch PC and issues single-outstanding word requests to instruction memory over a valid/ready request and valid response interface. It delivers {pc, inst} through the IF/ID pipeline register to the decode stage, honouring the decode data-hazard stall and the branch/jump redirect-flush. A 1-entry skid buffer absorbs a response that returns while decode is stalled.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset
INST_W, 32, instruction width (equals CPU_WIDTH)
PC_W, 64, PC / address width

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high; all flops reset immediately on assertion
stall  in  1  decode hazard stall; IF/ID register must hold
flush  in  1  control-hazard flush from decode/execute (branch or jump taken)
redirect_pc  in  PC_W  target PC; valid when flush=1
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  PC_W  fetch address, word aligned
imem_resp_valid  in  1  response data valid (exactly one per accepted request, ≥1 cycle later)
imem_resp_data  in  INST_W  fetched instruction
id_valid  out  1  IF/ID register holds a real instruction
id_pc  out  PC_W  PC of id_inst
id_inst  out  INST_W  instruction to decode

Behaviour:
- Reset values: id_valid=0, id_pc=0, id_inst=32'h0000_0013 (NOP), imem_req_valid=0, pc_q=RESET_PC, skid empty, state=S_RST.
- The FSM has four states:
  - S_RST: one cycle after reset deassertion, then S_REQ.
  - S_REQ: imem_req_valid=1 only if the skid is empty. imem_req_addr=pc_q. On handshake (valid&ready): req_pc<=pc_q, pc_q<=pc_q+4 (64-bit wrap, no carry out), go to S_WAIT.
  - S_WAIT: imem_req_valid=0. On imem_resp_valid: deliver {req_pc, data}, go to S_REQ.
  - S_DROP: imem_req_valid=0. On imem_resp_valid: discard the data, go to S_REQ.
- Consume: the decode stage consumes an instruction when id_valid & !stall.
- Delivery:
  - If the IF/ID register is empty or consumed this cycle, load the IF/ID register.
  - Otherwise load the skid buffer.
  - If the IF/ID register is consumed while the skid holds data, the skid moves to IF/ID and the skid clears. A response arriving in that same cycle goes to the skid.
- Stall: the IF/ID register holds its value exactly. At most two instructions are in flight (IF/ID plus skid), and requests pause while the skid is full.
- Flush has priority over stall and over every other update in the same cycle:
  - pc_q<=redirect_pc with bits[1:0] forced to 0.
  - id_valid<=0, id_inst<=NOP, skid cleared.
  - From S_WAIT with no response this cycle: go to S_DROP.
  - From S_WAIT with a response this cycle: the response is dropped and the FSM goes to S_REQ.
  - From S_REQ with a handshake this cycle: the request is issued from the old pc_q and the FSM goes to S_DROP.
  - From S_REQ without a handshake: stay in S_REQ with the new pc_q.
  - From S_DROP: stay in S_DROP; the single outstanding response is still discarded.
- First valid output latency: with 1-cycle memory, id_valid rises 3 cycles after reset release (S_RST, request, response). Throughput is one instruction per 2 cycles; pipelined fetch is out of scope.
- Reset mid-operation: all state clears asynchronously. Any in-flight response arriving after reset is ignored, because the FSM is in S_RST or S_REQ, not S_WAIT.

Decomposition:
- Shared defines header holds:
  - RESET_PC default
  - NOP_INST (32'h0000_0013)
  - FSM state encodings (2-bit: S_RST, S_REQ, S_WAIT, S_DROP)
  - INST_W tied to CPU_WIDTH
- One sub-module, if_skid_buf: 1-entry {pc, inst} holding register with load/pop/clear, valid flag and async active-high reset.

Test Plan:
- Reset, then 1-cycle-latency memory returning addr-dependent data → id_pc sequence 8000_0000, 8000_0004, 8000_0008 with matching id_inst; id_valid first high on the 3rd cycle after rst falls.
- stall=1 for 4 cycles while a response returns → id_pc/id_inst unchanged; the response lands in the skid; no new request is issued; stall drops → skid instruction appears the next cycle.
- Request accepted at 8000_0010, flush with redirect_pc=8000_0100 while waiting → late response discarded (S_DROP), next request addr 8000_0100, id_valid=0 until the 8000_0100 instruction arrives.
- flush coinciding with imem_resp_valid → that response is never presented; the next request is 8000_0100; skid empty.
- flush with redirect_pc=8000_0102 → imem_req_addr=8000_0100.
- 3-cycle memory latency with imem_req_ready low for 2 cycles → imem_req_addr held stable while valid=1; no duplicate requests; in-order PCs.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   CPU_WIDTH / INST_W_DEF : instruction width of the core
//   PC_W_DEF               : PC / address width
//   RESET_PC_DEF           : first fetch address after reset
//   NOP_INST               : addi x0,x0,0, shown on IF/ID when it holds no instruction
//   fetch_state_e          : fetch FSM encoding
package if_fetch_stage_pkg;

    localparam int CPU_WIDTH  = 32;
    localparam int INST_W_DEF = CPU_WIDTH;
    localparam int PC_W_DEF   = 64;

    localparam logic [63:0]          RESET_PC_DEF = 64'h0000_0000_8000_0000;
    localparam logic [CPU_WIDTH-1:0] NOP_INST     = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_skid_buf.sv
// One-entry {pc, inst} holding register that catches a fetch response
// arriving while the IF/ID register is stalled.
//   clk, rst          : clock, asynchronous active-high reset
//   load              : capture in_pc/in_inst (wins over pop in the same cycle)
//   pop               : entry handed to IF/ID this cycle
//   clear             : discard the entry (flush); wins over load and pop
//   in_pc, in_inst    : entry to capture
//   valid             : entry present
//   out_pc, out_inst  : held entry
module if_skid_buf
    import if_fetch_stage_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int INST_W = INST_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              pop,
    input  logic              clear,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    output logic              valid,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst
);

    localparam logic [INST_W-1:0] NOP = INST_W'(NOP_INST);

    logic              valid_q, valid_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            // pop+load: the old entry leaves while the new one takes its place
            valid_d = 1'b1;
            pc_d    = in_pc;
            inst_d  = in_inst;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= NOP;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    assign valid    = valid_q;
    assign out_pc   = pc_q;
    assign out_inst = inst_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues one outstanding word
// request at a time to instruction memory and delivers {pc, inst} to decode
// through the IF/ID register, with a one-entry skid for stalled responses.
//   clk, rst                      : clock, asynchronous active-high reset
//   stall                         : decode hazard, IF/ID holds
//   flush, redirect_pc            : taken branch/jump and its target
//   imem_req_valid/ready/addr     : request channel (word aligned address)
//   imem_resp_valid/data          : response channel, one per accepted request
//   id_valid, id_pc, id_inst      : IF/ID register contents
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int              INST_W   = INST_W_DEF,
    parameter int              PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [PC_W-1:0]   imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    output logic              id_valid,
    output logic [PC_W-1:0]   id_pc,
    output logic [INST_W-1:0] id_inst
);

    localparam logic [INST_W-1:0] NOP = INST_W'(NOP_INST);

    fetch_state_e      state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   req_pc_q, req_pc_d;
    logic              id_valid_q, id_valid_d;
    logic [PC_W-1:0]   id_pc_q, id_pc_d;
    logic [INST_W-1:0] id_inst_q, id_inst_d;

    logic              skid_valid, skid_load, skid_pop, skid_clear;
    logic [PC_W-1:0]   skid_pc;
    logic [INST_W-1:0] skid_inst;

    logic req_valid, handshake, resp_take, id_free;

    // A full skid means two instructions are already held, so stop fetching.
    assign req_valid = (state_q == S_REQ) && !skid_valid;
    assign handshake = req_valid && imem_req_ready;
    // Responses count only in S_WAIT; a flush in the same cycle kills them.
    assign resp_take = (state_q == S_WAIT) && imem_resp_valid && !flush;
    assign id_free   = !id_valid_q || !stall;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        case (state_q)
            S_RST: state_d = S_REQ;
            S_REQ: begin
                if (handshake) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + PC_W'(4);
                    // Request already left with the old PC; its reply is stale.
                    state_d  = flush ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) state_d = S_REQ;
                else if (flush)      state_d = S_DROP;
            end
            S_DROP: begin
                if (imem_resp_valid) state_d = S_REQ;
            end
            default: state_d = S_RST;
        endcase
        if (flush) pc_d = redirect_pc & ~PC_W'(3);
    end

    always_comb begin
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        skid_load  = 1'b0;
        skid_pop   = 1'b0;
        skid_clear = 1'b0;
        if (flush) begin
            id_valid_d = 1'b0;
            id_inst_d  = NOP;
            skid_clear = 1'b1;
        end else if (id_free) begin
            if (skid_valid) begin
                // Older skid entry goes first; a new response refills the skid.
                id_valid_d = 1'b1;
                id_pc_d    = skid_pc;
                id_inst_d  = skid_inst;
                skid_pop   = 1'b1;
                skid_load  = resp_take;
            end else if (resp_take) begin
                id_valid_d = 1'b1;
                id_pc_d    = req_pc_q;
                id_inst_d  = imem_resp_data;
            end else begin
                id_valid_d = 1'b0;
                id_inst_d  = NOP;
            end
        end else if (resp_take) begin
            skid_load = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_RST;
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_inst_q  <= NOP;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
        end
    end

    if_skid_buf #(
        .PC_W   (PC_W),
        .INST_W (INST_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (skid_load),
        .pop      (skid_pop),
        .clear    (skid_clear),
        .in_pc    (req_pc_q),
        .in_inst  (imem_resp_data),
        .valid    (skid_valid),
        .out_pc   (skid_pc),
        .out_inst (skid_inst)
    );

    assign imem_req_valid = req_valid;
    assign imem_req_addr  = pc_q;
    assign id_valid       = id_valid_q;
    assign id_pc          = id_pc_q;
    assign id_inst        = id_inst_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] DKEY = 32'h1357_9BDF;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_inst;

  if_fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .id_valid        (id_valid),
    .id_pc           (id_pc),
    .id_inst         (id_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: instructions held for decode form an in-order queue of
  // at most two; one request may be outstanding, possibly marked for discard.
  logic [63:0] m_q_pc[$];
  logic [31:0] m_q_inst[$];
  logic [63:0] m_next_pc;
  logic [63:0] m_out_addr;
  bit          m_started;
  bit          m_busy;
  bit          m_drop;
  logic [63:0] log_pc[$];
  logic [31:0] log_inst[$];

  // Memory environment.
  bit          mem_busy;
  int          mem_cnt;
  logic [63:0] mem_addr;
  int          lat = 1;

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    return a[31:0] ^ DKEY;
  endfunction

  function automatic bit m_req_valid();
    return m_started && !m_busy && (m_q_pc.size() < 2);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q_pc.delete();
    m_q_inst.delete();
    m_next_pc  = 64'h0000_0000_8000_0000;
    m_out_addr = '0;
    m_started  = 1'b0;
    m_busy     = 1'b0;
    m_drop     = 1'b0;
  endtask

  task automatic model_update();
    bit hs;
    bit cons;
    if (rst) begin
      model_reset();
    end else begin
      hs   = m_req_valid() && imem_req_ready;
      cons = (m_q_pc.size() > 0) && !stall;
      if (flush) begin
        m_q_pc.delete();
        m_q_inst.delete();
        if (hs) begin
          m_busy = 1'b1;
          m_drop = 1'b1;
        end else if (m_busy && imem_resp_valid) begin
          m_busy = 1'b0;
        end else if (m_busy) begin
          m_drop = 1'b1;
        end
        m_next_pc = redirect_pc & ~64'h3;
      end else begin
        if (cons) begin
          log_pc.push_back(m_q_pc[0]);
          log_inst.push_back(m_q_inst[0]);
          void'(m_q_pc.pop_front());
          void'(m_q_inst.pop_front());
        end
        if (m_busy && imem_resp_valid) begin
          if (!m_drop) begin
            m_q_pc.push_back(m_out_addr);
            m_q_inst.push_back(imem_resp_data);
          end
          m_busy = 1'b0;
        end
        if (hs) begin
          m_busy     = 1'b1;
          m_drop     = 1'b0;
          m_out_addr = m_next_pc;
          m_next_pc  = m_next_pc + 64'd4;
        end
      end
      m_started = 1'b1;
    end
  endtask

  task automatic mem_update();
    if (rst) begin
      mem_busy = 1'b0;
    end else begin
      if (imem_resp_valid) mem_busy = 1'b0;
      if (imem_req_valid && imem_req_ready) begin
        chk("mem_idle_on_req", 64'(mem_busy), 64'd0);
        mem_busy = 1'b1;
        mem_addr = imem_req_addr;
        mem_cnt  = lat;
      end
    end
  endtask

  task automatic mem_drive();
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    if (!rst && mem_busy) begin
      mem_cnt--;
      if (mem_cnt <= 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_data(mem_addr);
      end
    end
  endtask

  // Apply inputs for one cycle, advance through its rising edge.
  task automatic cycle(input logic s, input logic f, input logic [63:0] rpc, input logic rdy);
    stall          = s;
    flush          = f;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    @(posedge clk);
    model_update();
    mem_update();
    #1;
    mem_drive();
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_id_valid", 64'(id_valid), 64'd0);
      chk("rst_id_pc", id_pc, 64'd0);
      chk("rst_id_inst", 64'(id_inst), 64'(NOP));
      chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    end else begin
      chk("req_valid", 64'(imem_req_valid), 64'(m_req_valid()));
      if (m_req_valid()) chk("req_addr", imem_req_addr, m_next_pc);
      chk("id_valid", 64'(id_valid), 64'(m_q_pc.size() > 0));
      if (m_q_pc.size() > 0) begin
        chk("id_pc", id_pc, m_q_pc[0]);
        chk("id_inst", 64'(id_inst), 64'(m_q_inst[0]));
      end else begin
        chk("id_inst_bubble", 64'(id_inst), 64'(NOP));
      end
    end
  end

  initial begin
    logic        s;
    logic        f;
    logic        r;
    logic [63:0] rpc;
    rst             = 1'b0;
    stall           = 1'b0;
    flush           = 1'b0;
    redirect_pc     = '0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    mem_busy        = 1'b0;
    mem_cnt         = 0;
    mem_addr        = '0;
    model_reset();
    #1 rst = 1'b1;
    repeat (2) cycle(1'b0, 1'b0, 64'd0, 1'b1);
    rst = 1'b0;

    // First fetch latency and the straight-line PC sequence.
    repeat (2) cycle(1'b0, 1'b0, 64'd0, 1'b1);
    chk("first_valid_c2", 64'(id_valid), 64'd0);
    cycle(1'b0, 1'b0, 64'd0, 1'b1);
    chk("first_valid_c3", 64'(id_valid), 64'd1);
    chk("first_pc", id_pc, 64'h0000_0000_8000_0000);
    chk("first_inst", 64'(id_inst), 64'h9357_9BDF);
    repeat (4) cycle(1'b0, 1'b0, 64'd0, 1'b1);

    // Stall with a response landing in the skid.
    repeat (4) cycle(1'b1, 1'b0, 64'd0, 1'b1);
    chk("stall_hold_pc", id_pc, 64'h0000_0000_8000_0008);
    chk("stall_hold_inst", 64'(id_inst), 64'h9357_9BD7);
    chk("stall_no_req", 64'(imem_req_valid), 64'd0);
    cycle(1'b0, 1'b0, 64'd0, 1'b1);
    chk("skid_out_pc", id_pc, 64'h0000_0000_8000_000C);
    chk("skid_out_inst", 64'(id_inst), 64'h9357_9BD3);
    chk("log_len", 64'(log_pc.size()), 64'd3);
    if (log_pc.size() == 3) begin
      chk("log_pc0", log_pc[0], 64'h0000_0000_8000_0000);
      chk("log_pc1", log_pc[1], 64'h0000_0000_8000_0004);
      chk("log_pc2", log_pc[2], 64'h0000_0000_8000_0008);
      chk("log_inst2", 64'(log_inst[2]), 64'h9357_9BD7);
    end

    // Flush while waiting on a slow response.
    lat = 3;
    cycle(1'b0, 1'b0, 64'd0, 1'b1);
    cycle(1'b0, 1'b1, 64'h0000_0000_8000_0100, 1'b1);
    repeat (2) cycle(1'b0, 1'b0, 64'd0, 1'b1);
    chk("drop_req_valid", 64'(imem_req_valid), 64'd1);
    chk("drop_req_addr", imem_req_addr, 64'h0000_0000_8000_0100);
    chk("drop_id_valid", 64'(id_valid), 64'd0);
    lat = 1;
    cycle(1'b0, 1'b0, 64'd0, 1'b1);
    chk("redir_wait_id_valid", 64'(id_valid), 64'd0);
    cycle(1'b0, 1'b0, 64'd0, 1'b1);
    chk("redir_id_valid", 64'(id_valid), 64'd1);
    chk("redir_id_pc", id_pc, 64'h0000_0000_8000_0100);
    chk("redir_id_inst", 64'(id_inst), 64'h9357_9ADF);

    // Flush in the same cycle as a response.
    cycle(1'b0, 1'b0, 64'd0, 1'b1);
    cycle(1'b0, 1'b1, 64'h0000_0000_8000_0100, 1'b1);
    chk("fr_id_valid", 64'(id_valid), 64'd0);
    chk("fr_req_valid", 64'(imem_req_valid), 64'd1);
    chk("fr_req_addr", imem_req_addr, 64'h0000_0000_8000_0100);
    repeat (2) cycle(1'b0, 1'b0, 64'd0, 1'b1);
    chk("fr_next_valid", 64'(id_valid), 64'd1);
    chk("fr_next_pc", id_pc, 64'h0000_0000_8000_0100);

    // Misaligned redirect, then ready low with slow memory.
    cycle(1'b0, 1'b1, 64'h0000_0000_8000_0102, 1'b0);
    chk("align_req_valid", 64'(imem_req_valid), 64'd1);
    chk("align_req_addr", imem_req_addr, 64'h0000_0000_8000_0100);
    chk("align_id_valid", 64'(id_valid), 64'd0);
    lat = 3;
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b0, 64'd0, 1'b0);
      chk("nrdy_req_valid", 64'(imem_req_valid), 64'd1);
      chk("nrdy_req_addr", imem_req_addr, 64'h0000_0000_8000_0100);
    end
    cycle(1'b0, 1'b0, 64'd0, 1'b1);
    chk("nrdy_accepted", 64'(imem_req_valid), 64'd0);
    repeat (2) cycle(1'b0, 1'b0, 64'd0, 1'b1);
    chk("slow_not_yet", 64'(id_valid), 64'd0);
    cycle(1'b0, 1'b0, 64'd0, 1'b1);
    chk("slow_valid", 64'(id_valid), 64'd1);
    chk("slow_pc", id_pc, 64'h0000_0000_8000_0100);

    // Randomized traffic with one reset in the middle.
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) begin
        rst             = 1'b1;
        imem_resp_valid = 1'b0;
        repeat (2) cycle(1'b0, 1'b0, 64'd0, 1'b1);
        rst = 1'b0;
      end
      lat = $urandom_range(1, 4);
      s   = ($urandom_range(0, 99) < 30);
      f   = ($urandom_range(0, 99) < 3);
      r   = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 7) == 0)
        rpc = {56'hFF_FFFF_FFFF_FFFF, 8'($urandom_range(240, 255))};
      else
        rpc = 64'h0000_0000_8000_0000 + 64'($urandom_range(0, 1023));
      cycle(s, f, rpc, r);
    end

    repeat (2) cycle(1'b0, 1'b0, 64'd0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
